// File: rtl/f_fetch_fd_reg_if.sv
// f_fetch_fd_reg_if: instruction-memory request/response handshake between fetch and memory
interface f_fetch_fd_reg_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    modport master (output imem_req, imem_addr, input imem_rdata, imem_ready);
    modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/f_fetch_fd_reg.sv
// f_fetch_fd_reg: fetch stage PC register, imem request sequencing and F/D pipeline register
module f_fetch_fd_reg #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    f_fetch_fd_reg_if.master         imem,
    input  logic [31:0]              NPC,
    input  logic                     D_stall,
    output logic [31:0]              F_PC,
    output logic [31:0]              D_PC,
    output logic [31:0]              D_instr,
    output logic                     D_valid,
    output logic                     F_wait
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state;
    logic [31:0] hold_instr;
    logic        have_instr;
    logic        fire;
    logic [31:0] instr_sel;

    // HOLD replays an instruction captured while decode was stalled, so the delay slot is never refetched or lost
    always_comb begin
        have_instr = (state == FETCH && imem.imem_ready) || state == HOLD;
        instr_sel  = state == HOLD ? hold_instr : imem.imem_rdata;
        fire       = have_instr && !D_stall;
        F_wait     = !have_instr;
    end

    assign imem.imem_req  = state == FETCH;
    assign imem.imem_addr = {F_PC[31:2], 2'b00};

    // NPC is sampled on the same edge the current instruction moves to D, giving delay-slot semantics
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            F_PC       <= RESET_PC;
            D_PC       <= '0;
            D_instr    <= NOP_INSTR;
            D_valid    <= 1'b0;
            hold_instr <= '0;
        end else if (fire) begin
            D_instr <= instr_sel;
            D_PC    <= F_PC;
            D_valid <= 1'b1;
            F_PC    <= NPC;
            state   <= FETCH;
        end else if (state == IDLE) begin
            state <= FETCH;
        end else if (state == FETCH && imem.imem_ready) begin
            hold_instr <= imem.imem_rdata;
            state      <= HOLD;
        end
    end
endmodule

// File: tb/tb_f_fetch_fd_reg.sv
// tb_f_fetch_fd_reg: directed checks of fetch sequencing, latency, stall hold, delay slot, async reset and alignment
module tb_f_fetch_fd_reg;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        D_stall = 1'b0;
    logic        npc_force = 1'b0;
    logic [31:0] npc_val = '0;
    logic        use_fixed = 1'b0;
    logic [31:0] fixed_word = '0;
    logic [31:0] NPC, F_PC, D_PC, D_instr;
    logic        D_valid, F_wait;
    int          errors = 0;
    int          checks = 0;

    f_fetch_fd_reg_if bus ();

    f_fetch_fd_reg dut (
        .clk(clk), .reset_n(reset_n), .imem(bus.master), .NPC(NPC), .D_stall(D_stall),
        .F_PC(F_PC), .D_PC(D_PC), .D_instr(D_instr), .D_valid(D_valid), .F_wait(F_wait)
    );

    always #5 clk = ~clk;

    // memory returns a recognisable word per address unless a fixed word is forced
    assign bus.imem_rdata = use_fixed ? fixed_word : {16'hC0DE, bus.imem_addr[15:0]};
    assign NPC = npc_force ? npc_val : F_PC + 32'd4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_fpc", F_PC, 32'h3000);
        check("rst_dpc", D_PC, 32'h0);
        check("rst_dinstr", D_instr, 32'h0);
        check("rst_dvalid", {31'b0, D_valid}, 32'd0);
        check("rst_req", {31'b0, bus.imem_req}, 32'd0);
        step();
        reset_n = 1'b1;
        #1;
        check("idle_req", {31'b0, bus.imem_req}, 32'd0);
        check("idle_fwait", {31'b0, F_wait}, 32'd1);
    endtask

    initial begin
        bus.imem_ready = 1'b1;
        #1;
        // zero-wait streaming
        do_reset();
        step();
        check("t1_addr0", bus.imem_addr, 32'h3000);
        check("t1_req", {31'b0, bus.imem_req}, 32'd1);
        check("t1_dvalid0", {31'b0, D_valid}, 32'd0);
        step();
        check("t1_addr1", bus.imem_addr, 32'h3004);
        check("t1_dpc1", D_PC, 32'h3000);
        check("t1_dvalid1", {31'b0, D_valid}, 32'd1);
        check("t1_dinstr1", D_instr, 32'hC0DE3000);
        step();
        check("t1_addr2", bus.imem_addr, 32'h3008);
        check("t1_dpc2", D_PC, 32'h3004);
        // three wait cycles at 0x3004
        do_reset();
        step();
        step();
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_req", {31'b0, bus.imem_req}, 32'd1);
            check("t2_addr", bus.imem_addr, 32'h3004);
            check("t2_fwait", {31'b0, F_wait}, 32'd1);
            check("t2_dpc", D_PC, 32'h3000);
            step();
        end
        bus.imem_ready = 1'b1;
        #1;
        check("t2_rdy_fwait", {31'b0, F_wait}, 32'd0);
        step();
        check("t2_dpc_load", D_PC, 32'h3004);
        check("t2_dinstr", D_instr, 32'hC0DE3004);
        check("t2_fpc", F_PC, 32'h3008);
        // ready and stall together at 0x3008
        use_fixed = 1'b1;
        fixed_word = 32'h24010001;
        D_stall = 1'b1;
        #1;
        check("t3_fwait", {31'b0, F_wait}, 32'd0);
        step();
        use_fixed = 1'b0;
        #1;
        check("t3_hold_req", {31'b0, bus.imem_req}, 32'd0);
        check("t3_hold_fpc", F_PC, 32'h3008);
        check("t3_hold_dpc", D_PC, 32'h3004);
        step();
        check("t3_hold2_req", {31'b0, bus.imem_req}, 32'd0);
        check("t3_hold2_dpc", D_PC, 32'h3004);
        D_stall = 1'b0;
        #1;
        check("t3_rel_fwait", {31'b0, F_wait}, 32'd0);
        step();
        check("t3_dinstr", D_instr, 32'h24010001);
        check("t3_dpc", D_PC, 32'h3008);
        check("t3_fpc", F_PC, 32'h300C);
        check("t3_req", {31'b0, bus.imem_req}, 32'd1);
        // branch in D at 0x300C, delay slot at 0x3010
        step();
        check("t4_fpc_slot", F_PC, 32'h3010);
        npc_force = 1'b1;
        npc_val = 32'h3100;
        step();
        check("t4_dpc", D_PC, 32'h3010);
        check("t4_addr", bus.imem_addr, 32'h3100);
        // unaligned NPC
        npc_val = 32'h3102;
        step();
        check("t6_fpc", F_PC, 32'h3102);
        check("t6_addr", bus.imem_addr, 32'h3100);
        npc_force = 1'b0;
        // async reset while waiting in FETCH
        bus.imem_ready = 1'b0;
        step();
        check("t5_wait_req", {31'b0, bus.imem_req}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("t5_fpc", F_PC, 32'h3000);
        check("t5_dpc", D_PC, 32'h0);
        check("t5_dvalid", {31'b0, D_valid}, 32'd0);
        check("t5_req", {31'b0, bus.imem_req}, 32'd0);
        bus.imem_ready = 1'b1;
        step();
        reset_n = 1'b1;
        #1;
        check("t5_idle_req", {31'b0, bus.imem_req}, 32'd0);
        check("t5_idle_dvalid", {31'b0, D_valid}, 32'd0);
        step();
        check("t5_first_addr", bus.imem_addr, 32'h3000);
        check("t5_first_req", {31'b0, bus.imem_req}, 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/f_fetch_fd_reg.md
Name: f_fetch_fd_reg

Overview:
- Fetch stage of the P5 five-stage pipeline: owns the F-stage PC register, drives the instruction-memory request and owns the F/D pipeline register.
- Consumes the NPC produced combinationally from D-stage state by the next-PC block.
- Supplies F_PC, D_PC and the instruction to that block and to decode.
- Handles multi-cycle instruction memory and decode stalls without losing the branch delay slot.

Parameters:
- RESET_PC, 32'h00003000, first fetch address after reset.
- NOP_INSTR, 32'h00000000, instruction word shown in D while D_valid=0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- NPC  input  32  next fetch address from the next-PC block.
- D_stall  input  1  hazard-unit stall; hold PC and F/D.
- imem_rdata  input  32  instruction word; valid while imem_ready=1.
- imem_ready  input  1  memory has completed the current request; may be high in the same cycle the request is raised.
- imem_req  output  1  fetch request.
- imem_addr  output  32  word-aligned fetch address.
- F_PC  output  32  current fetch PC.
- D_PC  output  32  PC of the instruction held in D.
- D_instr  output  32  instruction held in D.
- D_valid  output  1  D holds a real fetched instruction.
- F_wait  output  1  fetch cannot supply an instruction this cycle; the hazard unit ORs this into its stall.

Behaviour:
- Reset (reset_n=0, async, effective immediately):
  - F_PC=RESET_PC, D_PC=0, D_instr=NOP_INSTR, D_valid=0.
  - hold_instr=0, state=IDLE, imem_req=0.
- States:
  - IDLE: post-reset only. Next clock goes to FETCH. imem_req=0, F_wait=1.
  - FETCH: imem_req=1, imem_addr={F_PC[31:2],2'b00}. imem_addr stays constant until imem_ready.
  - HOLD: the instruction is already captured in hold_instr. imem_req=0.
- Internal signals:
  - have_instr = (FETCH & imem_ready) | HOLD.
  - instr_sel = HOLD ? hold_instr : imem_rdata.
  - F_wait = ~have_instr (combinational).
  - fire = have_instr & ~D_stall.
- On fire:
  - D_instr <= instr_sel, D_PC <= F_PC, D_valid <= 1, F_PC <= NPC.
  - Next state is FETCH.
  - NPC is sampled in the same cycle as fire. This gives delay-slot semantics: a branch in D sees its delay slot in F, and the slot enters D while the PC takes the target.
- FETCH & imem_ready & D_stall: hold_instr <= imem_rdata, go to HOLD. PC and F/D are unchanged.
- FETCH & ~imem_ready: PC, F/D and hold_instr are unchanged, stay in FETCH. This holds regardless of D_stall.
- HOLD & D_stall: no change.
- HOLD & ~D_stall: fire using hold_instr, then return to FETCH.
- Throughput: with zero-wait memory (imem_ready tied 1) and no stall, exactly one fire per cycle, and F_PC advances every cycle.
- F_PC stores NPC unaligned. Only imem_addr is forced word-aligned. Misaligned-PC handling is out of scope.
- 32-bit arithmetic only; no overflow handling because no address computation is performed here.
- Reset asserted mid-request (FETCH or HOLD): all state is discarded, and any late imem_ready before the first FETCH is ignored.

Test Plan:
1. Release reset, imem_ready=1, NPC=F_PC+4 modelled, D_stall=0:
   - cycle 1 is IDLE with imem_req=0;
   - afterwards imem_addr reads 0x3000, 0x3004, 0x3008 on consecutive cycles;
   - D_PC trails by one cycle and D_valid=1 from the first fire.
2. Memory latency of 3 cycles at 0x3004:
   - imem_req and imem_addr=0x3004 hold for 3 cycles with F_wait=1;
   - D_PC stays 0x3000 and the instruction is loaded on the ready cycle.
3. imem_ready and D_stall both high at 0x3008 with rdata=0x24010001:
   - state goes to HOLD and imem_req=0;
   - after 2 stall cycles D_stall drops, D_instr=0x24010001, D_PC=0x3008, F_PC=NPC.
4. Branch in D (NPC=0x3100) with its delay slot at F_PC=0x3010:
   - on fire D_PC=0x3010 and the next imem_addr=0x3100.
5. Assert reset_n=0 while in FETCH waiting, mid-cycle:
   - outputs go to reset values immediately;
   - after release the first request is 0x3000.
6. NPC=0x00003102:
   - F_PC=0x3102 and imem_addr=0x3100.
